// File: rtl/load_align_unit_pkg.sv
// Shared encodings for the load/store data paths: funct3 codes, load FSM states
// and helpers that classify a load request.
package load_align_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store codes share the low funct3 encoding with the signed loads.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_LO = 3'd1,
        CAP_LO = 3'd2,
        CAP_HI = 3'd3,
        RESP   = 3'd4
    } state_t;

    function automatic logic is_legal(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    // A load splits when its last byte lands in the following word.
    function automatic logic is_split(input logic [2:0] f3, input logic [1:0] offset);
        case (f3)
            F3_LH, F3_LHU: return offset == 2'd3;
            F3_LW:         return offset != 2'd0;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align_unit_extract.sv
// Combinational byte/half/word select from a two-word window plus sign or zero
// extension; usable standalone.
module load_extract
    import load_align_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] lo,
    input  logic [DATA_WIDTH-1:0] hi,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int SH_W = $clog2(BYTE_WIDTH);

    logic [2*DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0]   w;
    logic [SH_W+1:0]         shamt;

    assign shamt  = {offset, {SH_W{1'b0}}};
    assign merged = {hi, lo} >> shamt;
    assign w      = merged[DATA_WIDTH-1:0];

    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:  result = {{(DATA_WIDTH-BYTE_WIDTH){w[BYTE_WIDTH-1]}}, w[BYTE_WIDTH-1:0]};
            F3_LBU: result = {{(DATA_WIDTH-BYTE_WIDTH){1'b0}}, w[BYTE_WIDTH-1:0]};
            F3_LH:  result = {{(DATA_WIDTH-2*BYTE_WIDTH){w[2*BYTE_WIDTH-1]}}, w[2*BYTE_WIDTH-1:0]};
            F3_LHU: result = {{(DATA_WIDTH-2*BYTE_WIDTH){1'b0}}, w[2*BYTE_WIDTH-1:0]};
            F3_LW:  result = w;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/load_align_unit.sv
// Load path: one request at a time, one or two word reads from a synchronous
// memory, then aligned/extended result presented for one cycle.
module load_align_unit
    import load_align_unit_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [2:0]               funct3,
    input  logic [ADDRESS_WIDTH-1:0] A,
    output logic                     mem_re,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    output logic [DATA_WIDTH-1:0]    result,
    output logic                     result_valid,
    output logic                     ld_illegal
);

    state_t state, state_nx;

    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [1:0]               off_q;
    logic [2:0]               f3_q;
    logic                     split_q;
    logic                     ill_q;
    logic [DATA_WIDTH-1:0]    lo_q;

    logic [DATA_WIDTH-1:0]    ext_lo, ext_hi, ext_result;

    // Read data is consumed straight off the port in the capture state that
    // completes the load, so no separate hi register is needed.
    assign ext_lo = (state == CAP_LO) ? mem_rdata : lo_q;
    assign ext_hi = (state == CAP_HI) ? mem_rdata : '0;

    load_extract #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_extract (
        .lo     (ext_lo),
        .hi     (ext_hi),
        .offset (off_q),
        .funct3 (f3_q),
        .result (ext_result)
    );

    always_comb begin
        state_nx = state;
        ld_ready = 1'b0;
        mem_re   = 1'b0;
        mem_addr = base_q;
        case (state)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid)
                    state_nx = is_legal(funct3) ? REQ_LO : RESP;
            end
            REQ_LO: begin
                mem_re   = 1'b1;
                state_nx = CAP_LO;
            end
            CAP_LO: begin
                if (split_q) begin
                    mem_re   = 1'b1;
                    mem_addr = base_q + ADDRESS_WIDTH'(4);
                    state_nx = CAP_HI;
                end else begin
                    state_nx = RESP;
                end
            end
            CAP_HI:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign result_valid = (state == RESP);
    assign ld_illegal   = (state == RESP) && ill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base_q  <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            split_q <= 1'b0;
            ill_q   <= 1'b0;
            lo_q    <= '0;
            result  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (ld_valid) begin
                        base_q  <= {A[ADDRESS_WIDTH-1:2], 2'b00};
                        off_q   <= A[1:0];
                        f3_q    <= funct3;
                        split_q <= is_split(funct3, A[1:0]);
                        ill_q   <= !is_legal(funct3);
                        if (!is_legal(funct3))
                            result <= '0;
                    end
                end
                CAP_LO: begin
                    lo_q <= mem_rdata;
                    if (!split_q)
                        result <= ext_result;
                end
                CAP_HI:  result <= ext_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Randomized and directed loads against a byte-addressed reference model.
module tb_load_align_unit;

    localparam int DW = 32;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [2:0]    funct3 = 3'b0;
    logic [AW-1:0] A = '0;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          ld_illegal;

    load_align_unit #(.DATA_WIDTH(DW), .BYTE_WIDTH(8), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .funct3(funct3), .A(A), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .result(result), .result_valid(result_valid),
        .ld_illegal(ld_illegal)
    );

    always #5 clk = ~clk;

    logic [31:0] memw [0:127];
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_re) mem_rdata <= memw[mem_addr[8:2]];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model works on byte addresses modulo the address space.
    function automatic logic [7:0] byte_at(input int addr);
        int x;
        logic [31:0] wd;
        x  = addr % 512;
        wd = memw[x / 4];
        return wd[8*(x%4) +: 8];
    endfunction

    function automatic int load_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f3, input int a);
        logic [31:0] w;
        w = {byte_at(a+3), byte_at(a+2), byte_at(a+1), byte_at(a)};
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b101:  return {16'b0, w[15:0]};
            3'b010:  return w;
            default: return 32'b0;
        endcase
    endfunction

    int          rdq[$];
    logic [31:0] exp_res;
    logic        exp_ill;
    int          exp_lat;
    int          acc_cyc;
    bit          pending = 0;
    bit          done = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_re) begin
                check("mem_re_while_ready", {31'b0, ld_ready}, 32'd0);
                check("mem_re_while_resp", {31'b0, result_valid}, 32'd0);
                checks++;
                if (rdq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: got addr %h expected no read", mem_addr);
                end else begin
                    check("read_addr", {23'b0, mem_addr}, rdq.pop_front());
                end
            end
            if (result_valid) begin
                checks++;
                if (!pending) begin
                    errors++;
                    $display("FAIL spurious_result: got result_valid 1 expected 0");
                end else begin
                    check("result", result, exp_res);
                    check("ld_illegal", {31'b0, ld_illegal}, {31'b0, exp_ill});
                    check("latency", cyc - acc_cyc, exp_lat);
                    check("reads_left", rdq.size(), 0);
                    pending = 0;
                    done = 1;
                end
            end else if (ld_illegal) begin
                check("ld_illegal_no_valid", 32'd1, 32'd0);
            end
        end
    end

    // Called on a negedge: present the request and record what must follow.
    task automatic issue(input logic [2:0] f3, input int a, output logic [31:0] mv);
        int t;
        int sz;
        int base;
        t = 0;
        while (!ld_ready && t < 20) begin @(negedge clk); t++; end
        checks++;
        if (!ld_ready) begin errors++; $display("FAIL ready_timeout: got ld_ready 0 expected 1"); end
        ld_valid = 1'b1;
        funct3   = f3;
        A        = AW'(a);
        mv       = model(f3, a);
        sz       = load_size(f3);
        exp_res  = mv;
        exp_ill  = (sz == 0);
        rdq.delete();
        if (sz == 0) exp_lat = 1;
        else begin
            base = a - (a % 4);
            rdq.push_back(base);
            if ((a % 4) + sz > 4) begin
                rdq.push_back((base + 4) % 512);
                exp_lat = 4;
            end else exp_lat = 3;
        end
        acc_cyc = cyc;
        done    = 0;
        pending = 1;
        @(negedge clk);
        ld_valid = 1'b0;
        funct3   = 3'($urandom);
        A        = AW'($urandom);
    endtask

    task automatic wait_result();
        int t;
        t = 0;
        while (!done && t < 20) begin @(negedge clk); t++; end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL result_timeout: got no result_valid expected one within 20 cycles");
            pending = 0;
            rdq.delete();
        end
    endtask

    task automatic do_load(input logic [2:0] f3, input int a, output logic [31:0] mv);
        issue(f3, a, mv);
        wait_result();
    endtask

    initial begin
        logic [31:0] mv;
        logic [2:0]  f3;
        for (int i = 0; i < 128; i++) memw[i] = $urandom;

        #1;
        check("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        check("rst_mem_re", {31'b0, mem_re}, 32'd0);
        check("rst_mem_addr", {23'b0, mem_addr}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_result_valid", {31'b0, result_valid}, 32'd0);
        check("rst_ld_illegal", {31'b0, ld_illegal}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        memw[4] = 32'h8899AABB;
        do_load(3'b010, 'h010, mv); check("lit_lw", mv, 32'h8899AABB);
        memw[4] = 32'h80112233;
        do_load(3'b000, 'h013, mv); check("lit_lb", mv, 32'hFFFFFF80);
        do_load(3'b100, 'h013, mv); check("lit_lbu", mv, 32'h00000080);
        memw[4] = 32'hF00D1234;
        do_load(3'b001, 'h012, mv); check("lit_lh", mv, 32'hFFFFF00D);
        do_load(3'b101, 'h012, mv); check("lit_lhu", mv, 32'h0000F00D);
        memw[4] = 32'hDDCCBBAA;
        memw[5] = 32'h44332211;
        do_load(3'b001, 'h013, mv); check("lit_lh_split", mv, 32'h000011DD);
        do_load(3'b010, 'h011, mv); check("lit_lw_split", mv, 32'h11DDCCBB);
        memw[127] = 32'hA1B2C3D4;
        memw[0]   = 32'h55667788;
        do_load(3'b010, 'h1FE, mv); check("lit_lw_wrap", mv, 32'h7788A1B2);
        do_load(3'b011, 'h010, mv); check("lit_illegal", mv, 32'h0);
        do_load(3'b111, 'h1FF, mv);

        // Reset while the second word of a split load is being read.
        issue(3'b010, 'h011, mv);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_mem_re", {31'b0, mem_re}, 32'd0);
        check("midrst_result_valid", {31'b0, result_valid}, 32'd0);
        check("midrst_ld_ready", {31'b0, ld_ready}, 32'd1);
        check("midrst_result", result, 32'd0);
        pending = 0;
        rdq.delete();
        @(negedge clk);
        check("midrst_hold_valid", {31'b0, result_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        do_load(3'b010, 'h011, mv); check("post_rst_lw", mv, 32'h11DDCCBB);

        for (int n = 0; n < 300; n++) begin
            if (n % 25 == 0)
                for (int i = 0; i < 128; i++) memw[i] = $urandom;
            case ($urandom_range(0, 11))
                0, 1:    f3 = 3'b000;
                2, 3:    f3 = 3'b100;
                4, 5:    f3 = 3'b001;
                6, 7:    f3 = 3'b101;
                8, 9:    f3 = 3'b010;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            do_load(f3, int'($urandom_range(0, 511)), mv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
